csa_sub64_pipe: RTL and testbench

CSA_SUB64_PIPE -- requirements
Module: csa_sub64_pipe

---
 rtl/csa_sub64_pipe_if.sv | 31 +++
 rtl/csa_sub64_pipe.sv | 108 ++++++++++
 tb/tb_csa_sub64_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/csa_sub64_pipe_if.sv
// csa_sub64_pipe_if: operand/result bundle for the two-stage 64-bit subtractor.
// Latency: none, signal grouping only.
// Backpressure: carries the in_valid/in_ready and out_valid/out_ready handshakes.
// Ports (slave = subtractor side):
//   in_valid, op1[63:0], op2[63:0], out_ready        -> into the subtractor
//   in_ready, out_valid, diff[63:0], borrow, [ovf]   <- out of the subtractor
// Macro SUB_OVF_FLAG_EN adds the registered signed-overflow flag ovf.
`timescale 1ns/1ps
interface csa_sub64_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        borrow;
`ifdef SUB_OVF_FLAG_EN
  logic        ovf;

  modport slave  (input  in_valid, op1, op2, out_ready,
                  output in_ready, out_valid, diff, borrow, ovf);
  modport master (output in_valid, op1, op2, out_ready,
                  input  in_ready, out_valid, diff, borrow, ovf);
`else
  modport slave  (input  in_valid, op1, op2, out_ready,
                  output in_ready, out_valid, diff, borrow);
  modport master (output in_valid, op1, op2, out_ready,
                  input  in_ready, out_valid, diff, borrow);
`endif
endinterface

// File: rtl/csa_sub64_pipe.sv
// csa_sub64_pipe: 64-bit subtractor (op1 - op2) split as a 32/32 carry-select adder.
// Latency: 2 register stages; accept edge loads stage 1, next edge presents the result.
// Backpressure: valid/ready per stage; holds 2 results, in_ready = !v1 || !v2 || out_ready.
// Ports: clock, reset (async, active-low), bus (csa_sub64_pipe_if.slave).
// Macro SUB_OVF_FLAG_EN: adds the pipelined signed-overflow flag bus.ovf.
`timescale 1ns/1ps
module csa_sub64_pipe (
  input  logic                  clock,
  input  logic                  reset,
  csa_sub64_pipe_if.slave       bus
);

  // Stage 1 state
  logic        v1;
  logic [31:0] s1_lo;
  logic        s1_c32;
  logic [32:0] s1_hi0;  // upper sum plus carry-out, carry-in 0
  logic [32:0] s1_hi1;  // upper sum plus carry-out, carry-in 1
`ifdef SUB_OVF_FLAG_EN
  logic        s1_a63;
  logic        s1_b63;
`endif

  // Stage 2 state
  logic        v2;
  logic [63:0] s2_diff;
  logic        s2_borrow;
`ifdef SUB_OVF_FLAG_EN
  logic        s2_ovf;
`endif

  logic        adv2;
  logic        acc1;

  // Stage 1 combinational: two's-complement subtract as op1 + ~op2 + 1.
  // The +1 enters the low half; the upper half is precomputed for both carry-ins.
  logic [32:0] lo_sum;
  logic [32:0] hi_sum0;
  logic [32:0] hi_sum1;

  // Stage 2 combinational: carry-select on the registered c32.
  logic [32:0] hi_sel;

  always_comb begin
    lo_sum  = {1'b0, bus.op1[31:0]}  + {1'b0, ~bus.op2[31:0]}  + 33'd1;
    hi_sum0 = {1'b0, bus.op1[63:32]} + {1'b0, ~bus.op2[63:32]};
    hi_sum1 = {1'b0, bus.op1[63:32]} + {1'b0, ~bus.op2[63:32]} + 33'd1;
    hi_sel  = s1_c32 ? s1_hi1 : s1_hi0;
  end

  // Stage 2 may move whenever it is empty or its result is being consumed;
  // stage 1 may load whenever it is empty or is about to hand off to stage 2.
  assign adv2 = !v2 || bus.out_ready;
  assign acc1 = !v1 || adv2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1     <= 1'b0;
      s1_lo  <= '0;
      s1_c32 <= 1'b0;
      s1_hi0 <= '0;
      s1_hi1 <= '0;
`ifdef SUB_OVF_FLAG_EN
      s1_a63 <= 1'b0;
      s1_b63 <= 1'b0;
`endif
    end else if (acc1) begin
      v1     <= bus.in_valid;
      s1_lo  <= lo_sum[31:0];
      s1_c32 <= lo_sum[32];
      s1_hi0 <= hi_sum0;
      s1_hi1 <= hi_sum1;
`ifdef SUB_OVF_FLAG_EN
      s1_a63 <= bus.op1[63];
      s1_b63 <= bus.op2[63];
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v2        <= 1'b0;
      s2_diff   <= '0;
      s2_borrow <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      s2_ovf    <= 1'b0;
`endif
    end else if (adv2) begin
      v2        <= v1;
      s2_diff   <= {hi_sel[31:0], s1_lo};
      // No carry out of bit 63 means op1 < op2 unsigned.
      s2_borrow <= ~hi_sel[32];
`ifdef SUB_OVF_FLAG_EN
      // Operands of opposite sign and a result whose sign differs from op1.
      s2_ovf    <= (s1_a63 != s1_b63) && (hi_sel[31] != s1_a63);
`endif
    end
  end

  assign bus.in_ready  = acc1;
  assign bus.out_valid = v2;
  assign bus.diff      = s2_diff;
  assign bus.borrow    = s2_borrow;
`ifdef SUB_OVF_FLAG_EN
  assign bus.ovf       = s2_ovf;
`endif

endmodule

// File: tb/tb_csa_sub64_pipe.sv
`timescale 1ns/1ps
module tb_csa_sub64_pipe;

  logic clock;
  logic reset;

  csa_sub64_pipe_if bus ();

  csa_sub64_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [63:0] d, input logic bo, input logic o);
    chk({tag, ".out_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, ".diff"}, bus.diff, d);
    chk({tag, ".borrow"}, {63'd0, bus.borrow}, {63'd0, bo});
`ifdef SUB_OVF_FLAG_EN
    chk({tag, ".ovf"}, {63'd0, bus.ovf}, {63'd0, o});
`endif
  endtask

  // Single operand pair with out_ready held high: result one edge after the accept edge.
  task automatic send(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] d, input logic bo, input logic o);
    bus.op1      = a;
    bus.op2      = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk({tag, ".lat"}, {63'd0, bus.out_valid}, 64'd0);
    step();
    chk_res(tag, d, bo, o);
    step();
    chk({tag, ".drain"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.out_ready = 1'b0;

    // Reset state, read while reset is still held.
    #3;
    chk("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst.in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("rst.diff",      bus.diff, 64'd0);
    chk("rst.borrow",    {63'd0, bus.borrow}, 64'd0);
`ifdef SUB_OVF_FLAG_EN
    chk("rst.ovf",       {63'd0, bus.ovf}, 64'd0);
`endif

    // Basic 5 - 3, presented across reset release so the first edge accepts it.
    #9;
    bus.op1       = 64'd5;
    bus.op2       = 64'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("basic.lat", {63'd0, bus.out_valid}, 64'd0);
    step();
    chk_res("basic", 64'd2, 1'b0, 1'b0);
    step();
    chk("basic.drain", {63'd0, bus.out_valid}, 64'd0);

    // Directed vectors.
    send("wrap",   64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    send("split",  64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    send("ovfneg", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    send("ovfpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         64'h8000_0000_0000_0000, 1'b1, 1'b1);
    send("equal",  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 1'b0);

    // Back-to-back stream with out_ready high: one result per cycle.
    bus.out_ready = 1'b1;
    bus.op1 = 64'd100; bus.op2 = 64'd1; bus.in_valid = 1'b1;
    step();
    bus.op1 = 64'd200; bus.op2 = 64'd2;
    step();
    chk_res("tp0", 64'd99, 1'b0, 1'b0);
    bus.op1 = 64'd300; bus.op2 = 64'd3;
    step();
    chk_res("tp1", 64'd198, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    step();
    chk_res("tp2", 64'd297, 1'b0, 1'b0);
    step();
    chk("tp.drain", {63'd0, bus.out_valid}, 64'd0);

    // Backpressure: A=10-1, B=20-2, C=30-3 with out_ready low for 4 cycles.
    bus.out_ready = 1'b0;
    bus.op1 = 64'd10; bus.op2 = 64'd1; bus.in_valid = 1'b1;
    step();
    chk("bp.rdy_after1", {63'd0, bus.in_ready}, 64'd1);
    bus.op1 = 64'd20; bus.op2 = 64'd2;
    step();
    chk("bp.rdy_full", {63'd0, bus.in_ready}, 64'd0);
    chk_res("bp.holdA0", 64'd9, 1'b0, 1'b0);
    bus.op1 = 64'd30; bus.op2 = 64'd3;
    step();
    chk("bp.rdy_full2", {63'd0, bus.in_ready}, 64'd0);
    chk_res("bp.holdA1", 64'd9, 1'b0, 1'b0);
    step();
    chk_res("bp.holdA2", 64'd9, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp.rdy_consume", {63'd0, bus.in_ready}, 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk_res("bp.B", 64'd18, 1'b0, 1'b0);
    chk("bp.rdy_shift", {63'd0, bus.in_ready}, 64'd1);
    step();
    chk_res("bp.C", 64'd27, 1'b0, 1'b0);
    step();
    chk("bp.drain", {63'd0, bus.out_valid}, 64'd0);

    // Reset mid-flight with both stages valid.
    bus.out_ready = 1'b0;
    bus.op1 = 64'd50; bus.op2 = 64'd5; bus.in_valid = 1'b1;
    step();
    bus.op1 = 64'd60; bus.op2 = 64'd6;
    step();
    bus.in_valid = 1'b0;
    chk_res("mid.full", 64'd45, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid.rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid.rst_ready", {63'd0, bus.in_ready},  64'd1);
    chk("mid.rst_diff",  bus.diff, 64'd0);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid.stale%0d", i), {63'd0, bus.out_valid}, 64'd0);
    end

    send("post", 64'h0000_0000_0000_1000, 64'h0000_0000_0000_0001,
         64'h0000_0000_0000_0FFF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
